input_feed_controller: RTL and testbench

//  Sequences the per-row input buffers (one buffer of matrixSize entries per systolic-array row).

---
 rtl/tpu_pkg.sv | 16 +
 rtl/skew_step_decoder.sv | 26 ++
 rtl/input_feed_controller.sv | 141 ++++++++++++++
 tb/tb_input_feed_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and helpers for the input feed controller
package tpu_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        FEED = 2'd2,
        DONE = 2'd3
    } feedState_t;

    // Address width for an n-entry buffer, never narrower than one bit.
    function automatic int addrWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/skew_step_decoder.sv
// rtl/skew_step_decoder.sv - maps a feed step to per-row valid flags and diagonally skewed read addresses
module skew_step_decoder
    import tpu_pkg::*;
#(
    parameter int matrixSize = 4,
    localparam int AW = addrWidth(matrixSize),
    localparam int SW = AW + 1
) (
    input  logic [SW-1:0]            stepIdx_i,
    output logic [matrixSize-1:0]    feedValid_o,
    output logic [matrixSize*AW-1:0] readLocation_o
);

    for (genvar r = 0; r < matrixSize; r++) begin : g_row
        logic [SW-1:0] lag;
        logic          active;

        // Row r consumes column (t - r) while that index lies inside the tile.
        assign lag    = stepIdx_i - SW'(r);
        assign active = (stepIdx_i >= SW'(r)) && (lag < SW'(matrixSize));

        assign feedValid_o[r]             = active;
        assign readLocation_o[r*AW +: AW] = active ? lag[AW-1:0] : '0;
    end

endmodule

// File: rtl/input_feed_controller.sv
// rtl/input_feed_controller.sv - loads a row-major tile into per-row buffers, then feeds them with diagonal skew
module input_feed_controller
    import tpu_pkg::*;
#(
    parameter int matrixSize = 4,
    parameter int dataSize   = 16,
    localparam int AW = addrWidth(matrixSize)
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [dataSize-1:0]      inData,
    input  logic                     startFeed,
    input  logic                     abort,
    input  logic                     stall,
    output logic [matrixSize-1:0]    writeEnable,
    output logic [dataSize-1:0]      writeElement,
    output logic [AW-1:0]            writeLocation,
    output logic [matrixSize*AW-1:0] readLocation,
    output logic [matrixSize-1:0]    feedValid,
    output logic                     busy,
    output logic                     feedDone
);

    localparam int            SW        = AW + 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(matrixSize - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(2 * matrixSize - 2);

    feedState_t               state_q;
    logic [AW-1:0]            row_q;
    logic [AW-1:0]            col_q;
    logic [SW-1:0]            step_q;
    logic [matrixSize-1:0]    writeEnable_q;
    logic [dataSize-1:0]      writeElement_q;
    logic [AW-1:0]            writeLocation_q;
    logic [matrixSize*AW-1:0] readLocation_q;
    logic [matrixSize-1:0]    feedValid_q;
    logic                     feedDone_q;

    logic [SW-1:0]            stepNext_d;
    logic [matrixSize-1:0]    decValid;
    logic [matrixSize*AW-1:0] decAddr;
    logic [matrixSize-1:0]    rowOneHot;

    // The decoder always looks one step ahead so its result lands in the output registers on time.
    assign stepNext_d = (state_q == FULL) ? '0 : step_q + SW'(1);
    assign rowOneHot  = {{(matrixSize-1){1'b0}}, 1'b1} << row_q;

    skew_step_decoder #(
        .matrixSize(matrixSize)
    ) u_decoder (
        .stepIdx_i      (stepNext_d),
        .feedValid_o    (decValid),
        .readLocation_o (decAddr)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= LOAD;
            row_q           <= '0;
            col_q           <= '0;
            step_q          <= '0;
            writeEnable_q   <= '0;
            writeElement_q  <= '0;
            writeLocation_q <= '0;
            readLocation_q  <= '0;
            feedValid_q     <= '0;
            feedDone_q      <= 1'b0;
        end else if (abort) begin
            state_q        <= LOAD;
            row_q          <= '0;
            col_q          <= '0;
            step_q         <= '0;
            writeEnable_q  <= '0;
            readLocation_q <= '0;
            feedValid_q    <= '0;
            feedDone_q     <= 1'b0;
        end else begin
            writeEnable_q <= '0;
            feedDone_q    <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (inValid) begin
                        writeEnable_q   <= rowOneHot;
                        writeElement_q  <= inData;
                        writeLocation_q <= col_q;
                        if (col_q == LAST_IDX) begin
                            col_q <= '0;
                            if (row_q == LAST_IDX) begin
                                row_q   <= '0;
                                state_q <= FULL;
                            end else begin
                                row_q <= row_q + AW'(1);
                            end
                        end else begin
                            col_q <= col_q + AW'(1);
                        end
                    end
                end
                FULL: begin
                    if (startFeed) begin
                        state_q        <= FEED;
                        step_q         <= '0;
                        feedValid_q    <= decValid;
                        readLocation_q <= decAddr;
                    end
                end
                FEED: begin
                    if (!stall) begin
                        if (step_q == STEP_LAST) begin
                            state_q        <= DONE;
                            feedValid_q    <= '0;
                            readLocation_q <= '0;
                            feedDone_q     <= 1'b1;
                        end else begin
                            step_q         <= stepNext_d;
                            feedValid_q    <= decValid;
                            readLocation_q <= decAddr;
                        end
                    end
                end
                DONE: begin
                    state_q <= LOAD;
                    step_q  <= '0;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign inReady       = (state_q == LOAD);
    assign busy          = (state_q != LOAD);
    assign writeEnable   = writeEnable_q;
    assign writeElement  = writeElement_q;
    assign writeLocation = writeLocation_q;
    assign readLocation  = readLocation_q;
    assign feedValid     = feedValid_q;
    assign feedDone      = feedDone_q;

endmodule

// File: tb/tb_input_feed_controller.sv
// tb/tb_input_feed_controller.sv - directed self-checking bench for input_feed_controller
module tb_input_feed_controller;

    logic        clk;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [15:0] inData;
    logic        startFeed;
    logic        abort;
    logic        stall;
    logic [3:0]  writeEnable;
    logic [15:0] writeElement;
    logic [1:0]  writeLocation;
    logic [7:0]  readLocation;
    logic [3:0]  feedValid;
    logic        busy;
    logic        feedDone;

    int compared   = 0;
    int mismatched = 0;

    // Expected per-step feed pattern for a 4x4 tile; readLocation packs row3..row0 as 2-bit fields.
    logic [3:0] expFv [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [7:0] expRl [7] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C, 8'hB0, 8'hC0};

    input_feed_controller #(
        .matrixSize(4),
        .dataSize  (16)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .inValid      (inValid),
        .inReady      (inReady),
        .inData       (inData),
        .startFeed    (startFeed),
        .abort        (abort),
        .stall        (stall),
        .writeEnable  (writeEnable),
        .writeElement (writeElement),
        .writeLocation(writeLocation),
        .readLocation (readLocation),
        .feedValid    (feedValid),
        .busy         (busy),
        .feedDone     (feedDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            inValid = 1'b1;
            inData  = base + 16'(i);
            tick();
            chk("load_we",   32'(writeEnable),   32'(4'b0001 << (i / 4)));
            chk("load_loc",  32'(writeLocation), 32'(i % 4));
            chk("load_data", 32'(writeElement),  32'(base + 16'(i)));
        end
        inValid = 1'b0;
        chk("full_ready", 32'(inReady), 32'd0);
    endtask

    task automatic feed_nostall();
        startFeed = 1'b1;
        tick();
        startFeed = 1'b0;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            chk($sformatf("feed_fv_t%0d", t), 32'(feedValid),    32'(expFv[t]));
            chk($sformatf("feed_rl_t%0d", t), 32'(readLocation), 32'(expRl[t]));
            chk("feed_nodone", 32'(feedDone), 32'd0);
        end
        tick();
        chk("done_pulse", 32'(feedDone),  32'd1);
        chk("done_fv",    32'(feedValid), 32'd0);
        chk("done_busy",  32'(busy),      32'd1);
        tick();
        chk("after_done", 32'(feedDone), 32'd0);
        chk("ready_back", 32'(inReady),  32'd1);
    endtask

    initial begin
        int fvCycles;
        int donePulses;

        resetN    = 1'b0;
        inValid   = 1'b0;
        inData    = '0;
        startFeed = 1'b0;
        abort     = 1'b0;
        stall     = 1'b0;
        #12;
        chk("rst_ready", 32'(inReady),      32'd1);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_we",    32'(writeEnable),  32'd0);
        chk("rst_fv",    32'(feedValid),    32'd0);
        chk("rst_rl",    32'(readLocation), 32'd0);
        chk("rst_done",  32'(feedDone),     32'd0);
        resetN = 1'b1;
        tick();

        // 1: back-to-back load of 1..16
        load_all(16'd1);
        chk("full_busy", 32'(busy), 32'd1);
        tick();
        chk("full_we_idle", 32'(writeEnable), 32'd0);
        chk("full_hold",    32'(inReady),     32'd0);

        // 2: unstalled feed
        feed_nostall();

        // 3: three stall cycles at t=2
        load_all(16'h0100);
        startFeed = 1'b1;
        tick();
        startFeed = 1'b0;
        tick();
        tick();
        chk("stall_t2_fv", 32'(feedValid), 32'b0111);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_fv", 32'(feedValid),    32'b0111);
            chk("stall_rl", 32'(readLocation), 32'h06);
        end
        stall = 1'b0;
        fvCycles   = 6;
        donePulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (feedValid != 4'b0000) fvCycles++;
            if (feedDone) donePulses++;
        end
        chk("stall_len",   32'(fvCycles),   32'd10);
        chk("stall_dones", 32'(donePulses), 32'd1);
        chk("stall_ready", 32'(inReady),    32'd1);

        // 4: gaps in the stream with startFeed pulsed during load
        for (int i = 0; i < 16; i++) begin
            inValid   = 1'b0;
            startFeed = 1'b1;
            tick();
            chk("gap_we",    32'(writeEnable), 32'd0);
            chk("gap_ready", 32'(inReady),     32'd1);
            inValid   = 1'b1;
            startFeed = 1'b0;
            inData    = 16'h0200 + 16'(i);
            tick();
            chk("gap_acc_we",  32'(writeEnable),   32'(4'b0001 << (i / 4)));
            chk("gap_acc_loc", 32'(writeLocation), 32'(i % 4));
        end
        inValid = 1'b0;
        chk("gap_full", 32'(inReady), 32'd0);

        // 5: abort at t=4, then a clean reload and feed
        startFeed = 1'b1;
        tick();
        startFeed = 1'b0;
        for (int t = 1; t <= 4; t++) tick();
        chk("pre_abort_fv", 32'(feedValid), 32'b1110);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_fv",    32'(feedValid), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_ready", 32'(inReady),   32'd1);
        chk("abort_done",  32'(feedDone),  32'd0);
        tick();
        chk("abort_done2", 32'(feedDone), 32'd0);
        load_all(16'h0300);
        feed_nostall();

        // 6: asynchronous reset in the middle of a load
        for (int i = 0; i < 7; i++) begin
            inValid = 1'b1;
            inData  = 16'h0400 + 16'(i);
            tick();
        end
        inValid = 1'b0;
        chk("preRst_we", 32'(writeEnable), 32'b0010);
        resetN = 1'b0;
        #1;
        chk("async_we",   32'(writeEnable),   32'd0);
        chk("async_data", 32'(writeElement),  32'd0);
        chk("async_loc",  32'(writeLocation), 32'd0);
        #2;
        resetN  = 1'b1;
        inValid = 1'b1;
        inData  = 16'hABCD;
        tick();
        inValid = 1'b0;
        chk("post_rst_we",   32'(writeEnable),   32'b0001);
        chk("post_rst_loc",  32'(writeLocation), 32'd0);
        chk("post_rst_data", 32'(writeElement),  32'hABCD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
